// File: rtl/systolic_skew_feeder_pkg.sv
// rtl/systolic_skew_feeder_pkg.sv - shared types and defaults for the systolic skew feeder
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int DEFAULT_ROWS  = 4;
  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - operand stream and skewed output bundle of the feeder
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_stall;
  logic [ROWS*WIDTH-1:0] out_data;
  logic [ROWS-1:0]       out_valid;
  logic                  tile_done;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_last, out_stall,
    input  in_ready, out_data, out_valid, tile_done, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_stall,
    output in_ready, out_data, out_valid, tile_done, busy
  );
endinterface

// File: rtl/systolic_skew_feeder_delay_line.sv
// rtl/systolic_skew_feeder_delay_line.sv - one row delay line; SYSTOLIC_SKEW_FEEDER_ZERO_FILL_EN zeroes bubble data
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             shift,
  input  logic             head_valid,
  input  logic [WIDTH-1:0] head_data,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (shift) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      valid_d[0] = head_valid;
`ifdef SYSTOLIC_SKEW_FEEDER_ZERO_FILL_EN
      data_d[0] = head_valid ? head_data : '0;
`else
      // Bubbles leave the head data register untouched; consumers gate on valid.
      data_d[0] = head_valid ? head_data : data_q[0];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_data  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skews row r by r cycles and drains each tile; SYSTOLIC_SKEW_FEEDER_ZERO_FILL_EN zero-fills bubbles
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clock,
  input  logic                    sclr,
  systolic_skew_feeder_if.slave   bus
);

  localparam int CW = cnt_width(ROWS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tile_done_q, tile_done_d;
  logic            advance;
  logic            in_ready;
  logic            accept;
  logic [ROWS-1:0] tail_valid;
  logic [ROWS*WIDTH-1:0] tail_data;

  assign advance = !bus.out_stall;
  assign accept  = bus.in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tile_done_q <= tile_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_done_d = tile_done_q;
    if (advance) begin
      tile_done_d = 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (!bus.in_last) begin
              state_d = STREAM;
            end else if (ROWS == 1) begin
              // A single row has no skew to drain; the vector lands on the output next cycle.
              state_d     = IDLE;
              tile_done_d = 1'b1;
            end else begin
              state_d = DRAIN;
              cnt_d   = CW'(ROWS - 1);
            end
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d     = IDLE;
            tile_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready      = advance && (state_q != DRAIN);
    bus.in_ready  = in_ready;
    bus.tile_done = tile_done_q;
    bus.busy      = (state_q != IDLE) || (|tail_valid);
    bus.out_valid = tail_valid;
    bus.out_data  = tail_data;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(WIDTH)
    ) u_line (
      .clock      (clock),
      .sclr       (sclr),
      .shift      (advance),
      .head_valid (accept),
      .head_data  (bus.in_data[r*WIDTH +: WIDTH]),
      .tail_valid (tail_valid[r]),
      .tail_data  (tail_data[r*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed self-checking bench for systolic_skew_feeder (ROWS=4 and ROWS=1)
module tb_systolic_skew_feeder;

  logic clock;
  logic sclr;
  int   n_tests;
  int   n_failed;

  systolic_skew_feeder_if #(.ROWS(4), .WIDTH(8)) bus4 ();
  systolic_skew_feeder_if #(.ROWS(1), .WIDTH(8)) bus1 ();

  systolic_skew_feeder #(.ROWS(4), .WIDTH(8)) u_dut4 (
    .clock (clock),
    .sclr  (sclr),
    .bus   (bus4)
  );

  systolic_skew_feeder #(.ROWS(1), .WIDTH(8)) u_dut1 (
    .clock (clock),
    .sclr  (sclr),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic s);
    bus4.in_valid  = v;
    bus4.in_last   = l;
    bus4.in_data   = d;
    bus4.out_stall = s;
    #1;
  endtask

  task automatic expect_rows(input string tag, input logic [3:0] ev, input logic [31:0] ed);
    logic [31:0] od;
    od = bus4.out_data;
    check({tag, "_valid"}, bus4.out_valid, ev);
    for (int r = 0; r < 4; r++)
      if (ev[r]) check($sformatf("%s_row%0d", tag, r), od[r*8 +: 8], ed[r*8 +: 8]);
  endtask

  task automatic run_head(input string tag);
    drive(1'b1, 1'b0, 32'h04030201, 1'b0);
    check({tag, "_c0_ready"}, bus4.in_ready, 1'b1);
    step();
    drive(1'b1, 1'b1, 32'h08070605, 1'b0);
    expect_rows({tag, "_c1"}, 4'b0001, 32'h00000001);
    step();
  endtask

  initial begin
    clock    = 1'b0;
    sclr     = 1'b1;
    n_tests  = 0;
    n_failed = 0;
    bus1.in_valid  = 1'b0;
    bus1.in_last   = 1'b0;
    bus1.in_data   = '0;
    bus1.out_stall = 1'b0;

    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom), 32'($urandom), 1'($urandom));
      step();
    end
    sclr = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_valid", bus4.out_valid, 4'b0000);
    check("rst_data", bus4.out_data, 32'h0);
    check("rst_tile_done", bus4.tile_done, 1'b0);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_ready", bus4.in_ready, 1'b1);
    check("rst1_valid", bus1.out_valid, 1'b0);

    // Single tile of two vectors, last accepted in cycle 1.
    run_head("tile");
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("tile_c2_ready", bus4.in_ready, 1'b0);
    check("tile_c2_busy", bus4.busy, 1'b1);
    expect_rows("tile_c2", 4'b0011, 32'h00000205);
    step();
    check("tile_c3_ready", bus4.in_ready, 1'b0);
    expect_rows("tile_c3", 4'b0110, 32'h00030600);
    step();
    check("tile_c4_ready", bus4.in_ready, 1'b0);
    check("tile_c4_done", bus4.tile_done, 1'b0);
    expect_rows("tile_c4", 4'b1100, 32'h04070000);
    step();
    check("tile_c5_ready", bus4.in_ready, 1'b1);
    check("tile_c5_done", bus4.tile_done, 1'b1);
    expect_rows("tile_c5", 4'b1000, 32'h08000000);
    step();
    check("tile_c6_done", bus4.tile_done, 1'b0);
    check("tile_c6_busy", bus4.busy, 1'b0);
    check("tile_c6_valid", bus4.out_valid, 4'b0000);

    // Same tile with a stall in cycle 3.
    run_head("stall");
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_c3_ready", bus4.in_ready, 1'b0);
    expect_rows("stall_c3", 4'b0110, 32'h00030600);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    expect_rows("stall_c4_hold", 4'b0110, 32'h00030600);
    check("stall_c4_done", bus4.tile_done, 1'b0);
    step();
    expect_rows("stall_c5", 4'b1100, 32'h04070000);
    check("stall_c5_done", bus4.tile_done, 1'b0);
    step();
    check("stall_c6_done", bus4.tile_done, 1'b1);
    check("stall_c6_ready", bus4.in_ready, 1'b1);
    expect_rows("stall_c6", 4'b1000, 32'h08000000);
    step();
    check("stall_c7_done", bus4.tile_done, 1'b0);

    // Bubble between two vectors.
    drive(1'b1, 1'b0, 32'h0E0D0C0B, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h18171615, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    expect_rows("bub_c3", 4'b0101, 32'h000D0015);
    step();
    check("bub_c4_valid", bus4.out_valid, 4'b1010);
`ifdef SYSTOLIC_SKEW_FEEDER_ZERO_FILL_EN
    check("bub_c4_row2_zero", bus4.out_data[23:16], 8'h00);
`endif
    step();
    expect_rows("bub_c5", 4'b0100, 32'h00170000);
    check("bub_c5_done", bus4.tile_done, 1'b0);
    step();
    check("bub_c6_done", bus4.tile_done, 1'b1);
    expect_rows("bub_c6", 4'b1000, 32'h18000000);
    step();

    // Reset in cycle 2 of a tile.
    run_head("mid");
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    #1;
    check("mid_c3_valid", bus4.out_valid, 4'b0000);
    check("mid_c3_data", bus4.out_data, 32'h0);
    check("mid_c3_busy", bus4.busy, 1'b0);
    check("mid_c3_ready", bus4.in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mid_done_%0d", i), bus4.tile_done, 1'b0);
      step();
    end

    // ROWS=1 single-vector tile.
    bus1.in_valid = 1'b1;
    bus1.in_last  = 1'b1;
    bus1.in_data  = 8'd9;
    #1;
    check("r1_c0_ready", bus1.in_ready, 1'b1);
    step();
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.in_data  = 8'd0;
    #1;
    check("r1_c1_data", bus1.out_data, 8'd9);
    check("r1_c1_valid", bus1.out_valid, 1'b1);
    check("r1_c1_done", bus1.tile_done, 1'b1);
    check("r1_c1_ready", bus1.in_ready, 1'b1);
    step();
    check("r1_c2_valid", bus1.out_valid, 1'b0);
    check("r1_c2_done", bus1.tile_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
